// File: rtl/zet_ng_soc_rst_seq.sv
// Reset sequencer: synchronizes the external reset, holds all domains, then releases them in staggered order.
// Optional watchdog restart is compiled in with ZET_NG_SOC_RST_SEQ_WDT_EN.
module zet_ng_soc_rst_seq #(
    parameter int N_DOMAINS   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int WDT_CYCLES  = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_rst_req,
    input  logic                 wdt_kick,
    output logic [N_DOMAINS-1:0] domain_rst,
    output logic                 seq_done,
    output logic [1:0]           rst_cause
);

    localparam logic [1:0] S_ASSERT  = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STG_W  = $clog2(STAGGER + 1);
    localparam int REL_W  = $clog2(N_DOMAINS + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   int_rst;
    logic [1:0]             state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [STG_W-1:0]       stg_q, stg_d;
    logic [REL_W-1:0]       rel_q, rel_d;
    logic [1:0]             cause_q, cause_d;
    logic                   sw_prev_q;
    logic                   sw_req;
    logic                   wdt_exp;

    // Release of the internal reset is synchronous; assertion follows rst immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign int_rst = ~sync_q[SYNC_STAGES-1];
    assign sw_req  = sw_rst_req & ~sw_prev_q;

`ifdef ZET_NG_SOC_RST_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);

    logic [WDT_W-1:0] wdt_q, wdt_d;

    assign wdt_exp = (state_q == S_RUN) && !wdt_kick && (wdt_q == WDT_W'(WDT_CYCLES - 1));

    // Counts only while staying in RUN, so every entry to RUN starts from zero.
    always_comb begin
        wdt_d = '0;
        if (state_q == S_RUN && state_d == S_RUN && !wdt_kick) begin
            wdt_d = wdt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic unused_wdt;

    assign wdt_exp    = 1'b0;
    assign unused_wdt = wdt_kick ^ WDT_CYCLES[0];
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        rel_d   = rel_q;
        cause_d = cause_q;
        if (int_rst) begin
            state_d = S_ASSERT;
            hold_d  = '0;
            stg_d   = '0;
            rel_d   = '0;
        end else begin
            case (state_q)
                S_ASSERT: begin
                    if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
                        state_d = S_RELEASE;
                        hold_d  = '0;
                        stg_d   = '0;
                        rel_d   = REL_W'(1);
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    // rel_q counts released domains, so release order is inherently ascending.
                    if (rel_q == REL_W'(N_DOMAINS)) begin
                        state_d = S_RUN;
                    end else if (stg_q == STG_W'(STAGGER - 1)) begin
                        rel_d = rel_q + REL_W'(1);
                        stg_d = '0;
                    end else begin
                        stg_d = stg_q + STG_W'(1);
                    end
                end
                S_RUN: begin
                    if (sw_req || wdt_exp) begin
                        state_d = S_ASSERT;
                        hold_d  = '0;
                        stg_d   = '0;
                        rel_d   = '0;
                        cause_d = sw_req ? 2'b01 : 2'b10;
                    end
                end
                default: begin
                    state_d = S_ASSERT;
                    hold_d  = '0;
                    stg_d   = '0;
                    rel_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_ASSERT;
            hold_q    <= '0;
            stg_q     <= '0;
            rel_q     <= '0;
            cause_q   <= 2'b00;
            sw_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stg_q     <= stg_d;
            rel_q     <= rel_d;
            cause_q   <= cause_d;
            sw_prev_q <= sw_rst_req;
        end
    end

    always_comb begin
        domain_rst = '1;
        for (int i = 0; i < N_DOMAINS; i++) begin
            domain_rst[i] = (rel_q <= REL_W'(i));
        end
    end

    assign seq_done  = (state_q == S_RUN);
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_zet_ng_soc_rst_seq.sv
// Bench for zet_ng_soc_rst_seq: N=3, SYNC=2, HOLD=4, STAGGER=2, WDT=16.
// Watchdog cases run when ZET_NG_SOC_RST_SEQ_WDT_EN is defined; otherwise the kick is checked to be ignored.
module tb_zet_ng_soc_rst_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       wdt_kick = 1'b0;
    logic [2:0] domain_rst;
    logic       seq_done;
    logic [1:0] rst_cause;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic       sw;
        logic [2:0] dom;
        logic       done;
        logic [1:0] cause;
    } vec_t;

    vec_t tbl[$];

    zet_ng_soc_rst_seq #(
        .N_DOMAINS  (3),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(4),
        .STAGGER    (2),
        .WDT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_rst_req(sw_rst_req),
        .wdt_kick  (wdt_kick),
        .domain_rst(domain_rst),
        .seq_done  (seq_done),
        .rst_cause (rst_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input logic sw, input logic [2:0] dom, input logic done, input logic [1:0] cause);
        vec_t v;
        v.sw = sw; v.dom = dom; v.done = done; v.cause = cause;
        tbl.push_back(v);
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic s, input logic k);
        sw_rst_req = s;
        wdt_kick   = k;
        @(posedge clk);
        #1;
    endtask

    // Steps `lead` sync edges, then edges 0..10 of a release sequence, checking the expected release profile.
    task automatic run_seq(input string tag, input logic [1:0] cause, input int lead);
        logic [2:0] ed;
        for (int j = 0; j < lead; j++) begin
            step(1'b0, 1'b0);
            chk($sformatf("%s sync%0d dom", tag, j), 32'(domain_rst), 32'(3'b111));
        end
        for (int k = 0; k <= 10; k++) begin
            step(1'b0, 1'b0);
            ed = (k < 4) ? 3'b111 : (k < 6) ? 3'b110 : (k < 8) ? 3'b100 : 3'b000;
            chk($sformatf("%s e%0d dom", tag, k), 32'(domain_rst), 32'(ed));
            chk($sformatf("%s e%0d done", tag, k), 32'(seq_done), 32'(k >= 9));
            chk($sformatf("%s e%0d cause", tag, k), 32'(rst_cause), 32'(cause));
        end
    endtask

    initial begin
        int restarts;

        // Power-on: two sync edges, then edges 0..10 (release at 4/6/8, done at 9).
        repeat (6) add(1'b0, 3'b111, 1'b0, 2'b00);
        repeat (2) add(1'b0, 3'b110, 1'b0, 2'b00);
        repeat (2) add(1'b0, 3'b100, 1'b0, 2'b00);
        add(1'b0, 3'b000, 1'b0, 2'b00);
        repeat (2) add(1'b0, 3'b000, 1'b1, 2'b00);
        // One-cycle software request in RUN; restart edge then edges 0..9.
        add(1'b1, 3'b111, 1'b0, 2'b01);
        repeat (4) add(1'b0, 3'b111, 1'b0, 2'b01);
        repeat (2) add(1'b0, 3'b110, 1'b0, 2'b01);
        repeat (2) add(1'b0, 3'b100, 1'b0, 2'b01);
        add(1'b0, 3'b000, 1'b0, 2'b01);
        add(1'b0, 3'b000, 1'b1, 2'b01);
        // Restart, then request held high from edge 2 to edge 12: ignored while sequencing and while level stays high.
        add(1'b1, 3'b111, 1'b0, 2'b01);
        repeat (2) add(1'b0, 3'b111, 1'b0, 2'b01);
        repeat (2) add(1'b1, 3'b111, 1'b0, 2'b01);
        repeat (2) add(1'b1, 3'b110, 1'b0, 2'b01);
        repeat (2) add(1'b1, 3'b100, 1'b0, 2'b01);
        add(1'b1, 3'b000, 1'b0, 2'b01);
        repeat (4) add(1'b1, 3'b000, 1'b1, 2'b01);
        repeat (2) add(1'b0, 3'b000, 1'b1, 2'b01);

        #1;
        chk("reset dom", 32'(domain_rst), 32'(3'b111));
        chk("reset done", 32'(seq_done), 32'(1'b0));
        chk("reset cause", 32'(rst_cause), 32'(2'b00));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].sw, 1'b0);
            chk($sformatf("row%0d dom", i), 32'(domain_rst), 32'(tbl[i].dom));
            chk($sformatf("row%0d done", i), 32'(seq_done), 32'(tbl[i].done));
            chk($sformatf("row%0d cause", i), 32'(rst_cause), 32'(tbl[i].cause));
        end

`ifdef ZET_NG_SOC_RST_SEQ_WDT_EN
        // Kick, then 16 unkicked RUN edges: expiry on the 16th.
        step(1'b0, 1'b1);
        repeat (15) step(1'b0, 1'b0);
        chk("wdt pre-expiry done", 32'(seq_done), 32'(1'b1));
        step(1'b0, 1'b0);
        chk("wdt expiry dom", 32'(domain_rst), 32'(3'b111));
        chk("wdt expiry done", 32'(seq_done), 32'(1'b0));
        chk("wdt expiry cause", 32'(rst_cause), 32'(2'b10));
        run_seq("wdt", 2'b10, 0);

        restarts = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, (i % 10) == 0);
            if (!seq_done) restarts++;
        end
        chk("wdt kicked restarts", 32'(restarts), 32'd0);

        // Software request on the expiry edge wins.
        step(1'b0, 1'b1);
        repeat (15) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("simul dom", 32'(domain_rst), 32'(3'b111));
        chk("simul cause", 32'(rst_cause), 32'(2'b01));
        run_seq("simul", 2'b01, 0);
`else
        step(1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0);
        chk("nowdt done", 32'(seq_done), 32'(1'b1));
        chk("nowdt cause", 32'(rst_cause), 32'(2'b01));
`endif

        // Asynchronous abort at edge 5 of a software-triggered sequence.
        step(1'b1, 1'b0);
        chk("abort restart cause", 32'(rst_cause), 32'(2'b01));
        for (int k = 0; k <= 5; k++) step(1'b0, 1'b0);
        chk("abort e5 dom", 32'(domain_rst), 32'(3'b110));
        rst = 1'b0;
        #1;
        chk("abort async dom", 32'(domain_rst), 32'(3'b111));
        chk("abort async done", 32'(seq_done), 32'(1'b0));
        chk("abort async cause", 32'(rst_cause), 32'(2'b00));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_seq("abort", 2'b00, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
